parking_pw_checker: RTL and testbench

- Responder side of the parking controller's password handshake.
- The controller raises `pwstart` while it waits for a password. This block collects `DIGITS` hex digits from the switch/button front end, compares them to the stored code, and returns a one-cycle `pwdone` with `pw_correct` qualified.
- Also exposes `digit_cnt`, `busy` and `locked` for the 7-seg/LED display logic.

---
 rtl/parking_pkg.sv | 25 ++
 rtl/pw_timeout_cnt.sv | 37 +++
 rtl/parking_pw_checker.sv | 207 ++++++++++++++++++++
 tb/tb_parking_pw_checker.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking controller and its password checker.
package parking_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam logic [15:0] DEFAULT_PW = 16'h1234;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_CHECK   = 3'd2,
        ST_DONE    = 3'd3,
        ST_LOCKED  = 3'd4
    } pw_state_e;

    // Display states the controller drives onto the 7-seg/LED logic.
    typedef enum logic [2:0] {
        SEG_IDLE     = 3'd0,
        SEG_PW_ENTRY = 3'd1,
        SEG_PW_OK    = 3'd2,
        SEG_PW_FAIL  = 3'd3,
        SEG_LOCKED   = 3'd4,
        SEG_FULL     = 3'd5
    } segstate_e;

endpackage

// File: rtl/pw_timeout_cnt.sv
// Saturating cycle timer: clr_i restarts the interval, en_i advances it, tc_o flags expiry.
module pw_timeout_cnt #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LOAD = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Down-counter holding the cycles left; stops at zero instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/parking_pw_checker.sv
// Password responder for the parking controller; optional lockout via PW_LOCKOUT_EN.
// state   | meaning
// IDLE    | waiting for pwstart, stored code may be reloaded
// COLLECT | shifting in digits, entry timeout running
// CHECK   | comparing entry against the stored code
// DONE    | result issued, waiting for pwstart to drop
// LOCKED  | too many failures, every request answered as wrong
module parking_pw_checker #(
    parameter int unsigned DIGITS = 4,
    parameter logic [DIGITS*parking_pkg::DIGIT_W-1:0] DEFAULT_PW = parking_pkg::DEFAULT_PW,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter int unsigned MAX_TRIES = 3,
    parameter int unsigned LOCK_CYCLES = 1_000_000_000
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  pwstart_i,
    input  logic [parking_pkg::DIGIT_W-1:0]        digit_in_i,
    input  logic                                  digit_strobe_i,
    input  logic                                  clear_i,
    input  logic                                  pw_set_i,
    input  logic [DIGITS*parking_pkg::DIGIT_W-1:0] pw_new_i,
    output logic                                  pwdone_o,
    output logic                                  pw_correct_o,
    output logic [2:0]                            digit_cnt_o,
    output logic                                  busy_o,
    output logic                                  locked_o
);

    import parking_pkg::*;

    localparam int unsigned PW_W = DIGITS * DIGIT_W;
    localparam logic [2:0] LAST_DIGIT = 3'(DIGITS - 1);

    if (DIGITS < 2 || DIGITS > 7 || TIMEOUT_CYCLES < 2 || MAX_TRIES < 1 || LOCK_CYCLES < 2)
    begin : g_param_check
        $error("parking_pw_checker: unsupported parameter set");
    end

    pw_state_e       state_q;
    logic [PW_W-1:0] code_q;
    logic [PW_W-1:0] entry_q;
    logic [2:0]      cnt_q;
    logic            pwdone_q;
    logic            pw_correct_q;
    logic            busy_q;
    logic            code_match;
    logic            to_clr;
    logic            to_tc;

    assign code_match = (entry_q == code_q);

    // Any accepted keypress restarts the idle interval.
    assign to_clr = (state_q != ST_COLLECT) || digit_strobe_i || clear_i;

    pw_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_entry_timeout (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (to_clr),
        .en_i   (state_q == ST_COLLECT),
        .tc_o   (to_tc)
    );

`ifdef PW_LOCKOUT_EN
    localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_TRIES);

    logic [FAIL_W-1:0] fail_q;
    logic              locked_q;
    logic              lock_ack_q;
    logic              lock_tc;

    pw_timeout_cnt #(
        .LIMIT (LOCK_CYCLES)
    ) u_lock_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state_q != ST_LOCKED),
        .en_i   (state_q == ST_LOCKED),
        .tc_o   (lock_tc)
    );

    assign locked_o = locked_q;
`else
    assign locked_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            code_q       <= DEFAULT_PW;
            entry_q      <= '0;
            cnt_q        <= '0;
            pwdone_q     <= 1'b0;
            pw_correct_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef PW_LOCKOUT_EN
            fail_q       <= '0;
            locked_q     <= 1'b0;
            lock_ack_q   <= 1'b0;
`endif
        end else begin
            pwdone_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pw_set_i) begin
                        code_q <= pw_new_i;
                    end
                    if (pwstart_i) begin
                        state_q      <= ST_COLLECT;
                        cnt_q        <= '0;
                        entry_q      <= '0;
                        pw_correct_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end

                // Abort outranks clear, clear outranks a same-cycle strobe.
                ST_COLLECT: begin
                    if (!pwstart_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (clear_i) begin
                        cnt_q   <= '0;
                        entry_q <= '0;
                    end else if (digit_strobe_i) begin
                        entry_q <= {entry_q[PW_W-DIGIT_W-1:0], digit_in_i};
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == LAST_DIGIT) begin
                            state_q <= ST_CHECK;
                        end
                    end else if (to_tc) begin
                        state_q      <= ST_DONE;
                        pwdone_q     <= 1'b1;
                        pw_correct_q <= 1'b0;
                        busy_q       <= 1'b0;
`ifdef PW_LOCKOUT_EN
                        if (fail_q != FAIL_MAX) begin
                            fail_q <= fail_q + 1'b1;
                        end
`endif
                    end
                end

                ST_CHECK: begin
                    state_q      <= ST_DONE;
                    pwdone_q     <= 1'b1;
                    pw_correct_q <= code_match;
                    busy_q       <= 1'b0;
`ifdef PW_LOCKOUT_EN
                    if (code_match) begin
                        fail_q <= '0;
                    end else if (fail_q != FAIL_MAX) begin
                        fail_q <= fail_q + 1'b1;
                    end
`endif
                end

                ST_DONE: begin
                    if (!pwstart_i) begin
`ifdef PW_LOCKOUT_EN
                        if (fail_q == FAIL_MAX) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
`else
                        state_q <= ST_IDLE;
`endif
                    end
                end

`ifdef PW_LOCKOUT_EN
                // Requests during lockout get one wrong-answer pulse each so the controller moves on.
                ST_LOCKED: begin
                    if (lock_tc) begin
                        state_q    <= ST_IDLE;
                        locked_q   <= 1'b0;
                        fail_q     <= '0;
                        lock_ack_q <= 1'b0;
                    end else if (pwstart_i && !lock_ack_q) begin
                        pwdone_q     <= 1'b1;
                        pw_correct_q <= 1'b0;
                        lock_ack_q   <= 1'b1;
                    end else if (!pwstart_i) begin
                        lock_ack_q <= 1'b0;
                    end
                end
`endif

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pwdone_o     = pwdone_q;
    assign pw_correct_o = pw_correct_q;
    assign digit_cnt_o  = cnt_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_parking_pw_checker.sv
// Directed bench for parking_pw_checker: vector table plus multi-cycle corner sequences.
module tb_parking_pw_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwstart = 1'b0;
    logic [3:0]  digit = 4'h0;
    logic        strobe = 1'b0;
    logic        clr = 1'b0;
    logic        pw_set = 1'b0;
    logic [15:0] pw_new = 16'h0000;
    logic        pwdone, pw_correct, busy, locked;
    logic [2:0]  digit_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    parking_pw_checker #(
        .DIGITS         (4),
        .DEFAULT_PW     (16'h1234),
        .TIMEOUT_CYCLES (20),
        .MAX_TRIES      (3),
        .LOCK_CYCLES    (50)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .pwstart_i      (pwstart),
        .digit_in_i     (digit),
        .digit_strobe_i (strobe),
        .clear_i        (clr),
        .pw_set_i       (pw_set),
        .pw_new_i       (pw_new),
        .pwdone_o       (pwdone),
        .pw_correct_o   (pw_correct),
        .digit_cnt_o    (digit_cnt),
        .busy_o         (busy),
        .locked_o       (locked)
    );

    typedef struct {
        logic        ps;
        logic [3:0]  dg;
        logic        st;
        logic        cl;
        logic        set;
        logic [15:0] nw;
        logic        e_done;
        logic        e_corr;
        logic [2:0]  e_cnt;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic ps, input logic [3:0] dg, input logic st,
                               input logic cl, input logic set, input logic [15:0] nw,
                               input logic e_done, input logic e_corr,
                               input logic [2:0] e_cnt, input logic e_busy);
        vec_t r;
        r.ps = ps; r.dg = dg; r.st = st; r.cl = cl; r.set = set; r.nw = nw;
        r.e_done = e_done; r.e_corr = e_corr; r.e_cnt = e_cnt; r.e_busy = e_busy;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_session(input logic [15:0] code, output logic done, output logic corr);
        pwstart = 1'b1;
        step();
        for (int i = 3; i >= 0; i--) begin
            digit  = code[i*4 +: 4];
            strobe = 1'b1;
            step();
        end
        strobe = 1'b0;
        step();
        done = pwdone;
        corr = pw_correct;
        pwstart = 1'b0;
        step();
    endtask

    initial begin
        logic d, c, seen;
        int   lat, n;

        // ---- correct entry ----
        vecs.push_back(v(1, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 1));
        vecs.push_back(v(1, 4'h1, 1, 0, 0, 16'h0, 0, 0, 1, 1));
        vecs.push_back(v(1, 4'h2, 1, 0, 0, 16'h0, 0, 0, 2, 1));
        vecs.push_back(v(1, 4'h3, 1, 0, 0, 16'h0, 0, 0, 3, 1));
        vecs.push_back(v(1, 4'h4, 1, 0, 0, 16'h0, 0, 0, 4, 1));
        vecs.push_back(v(1, 4'h0, 0, 0, 0, 16'h0, 1, 1, 4, 0));
        vecs.push_back(v(1, 4'h0, 0, 0, 0, 16'h0, 0, 1, 4, 0));
        vecs.push_back(v(0, 4'h0, 0, 0, 0, 16'h0, 0, 1, 4, 0));
        // ---- 1,2, clear, 9,9,9,9 -> wrong ----
        vecs.push_back(v(1, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 1));
        vecs.push_back(v(1, 4'h1, 1, 0, 0, 16'h0, 0, 0, 1, 1));
        vecs.push_back(v(1, 4'h2, 1, 0, 0, 16'h0, 0, 0, 2, 1));
        vecs.push_back(v(1, 4'h0, 0, 1, 0, 16'h0, 0, 0, 0, 1));
        vecs.push_back(v(1, 4'h9, 1, 0, 0, 16'h0, 0, 0, 1, 1));
        vecs.push_back(v(1, 4'h9, 1, 0, 0, 16'h0, 0, 0, 2, 1));
        vecs.push_back(v(1, 4'h9, 1, 0, 0, 16'h0, 0, 0, 3, 1));
        vecs.push_back(v(1, 4'h9, 1, 0, 0, 16'h0, 0, 0, 4, 1));
        vecs.push_back(v(1, 4'h0, 0, 0, 0, 16'h0, 1, 0, 4, 0));
        vecs.push_back(v(0, 4'h0, 0, 0, 0, 16'h0, 0, 0, 4, 0));
        // ---- clear beats a same-cycle strobe; discarded digits leave no trace ----
        vecs.push_back(v(1, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 1));
        vecs.push_back(v(1, 4'h5, 1, 0, 0, 16'h0, 0, 0, 1, 1));
        vecs.push_back(v(1, 4'h6, 1, 1, 0, 16'h0, 0, 0, 0, 1));
        vecs.push_back(v(1, 4'h1, 1, 0, 0, 16'h0, 0, 0, 1, 1));
        vecs.push_back(v(1, 4'h2, 1, 0, 0, 16'h0, 0, 0, 2, 1));
        vecs.push_back(v(1, 4'h3, 1, 0, 0, 16'h0, 0, 0, 3, 1));
        vecs.push_back(v(1, 4'h4, 1, 0, 0, 16'h0, 0, 0, 4, 1));
        vecs.push_back(v(1, 4'h0, 0, 0, 0, 16'h0, 1, 1, 4, 0));
        vecs.push_back(v(0, 4'h0, 0, 0, 0, 16'h0, 0, 1, 4, 0));
        // ---- reprogram to A5C3; pw_set in COLLECT ignored ----
        vecs.push_back(v(0, 4'h0, 0, 0, 1, 16'hA5C3, 0, 1, 4, 0));
        vecs.push_back(v(1, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 1));
        vecs.push_back(v(1, 4'h0, 0, 0, 1, 16'hFFFF, 0, 0, 0, 1));
        vecs.push_back(v(1, 4'hA, 1, 0, 0, 16'h0, 0, 0, 1, 1));
        vecs.push_back(v(1, 4'h5, 1, 0, 0, 16'h0, 0, 0, 2, 1));
        vecs.push_back(v(1, 4'hC, 1, 0, 0, 16'h0, 0, 0, 3, 1));
        vecs.push_back(v(1, 4'h3, 1, 0, 0, 16'h0, 0, 0, 4, 1));
        vecs.push_back(v(1, 4'h0, 0, 0, 0, 16'h0, 1, 1, 4, 0));
        vecs.push_back(v(0, 4'h0, 0, 0, 0, 16'h0, 0, 1, 4, 0));
        vecs.push_back(v(1, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 1));
        vecs.push_back(v(1, 4'h1, 1, 0, 0, 16'h0, 0, 0, 1, 1));
        vecs.push_back(v(1, 4'h2, 1, 0, 0, 16'h0, 0, 0, 2, 1));
        vecs.push_back(v(1, 4'h3, 1, 0, 0, 16'h0, 0, 0, 3, 1));
        vecs.push_back(v(1, 4'h4, 1, 0, 0, 16'h0, 0, 0, 4, 1));
        vecs.push_back(v(1, 4'h0, 0, 0, 0, 16'h0, 1, 0, 4, 0));
        vecs.push_back(v(0, 4'h0, 0, 0, 0, 16'h0, 0, 0, 4, 0));

        // ---- reset state ----
        step();
        step();
        check("reset outputs", {27'd0, pwdone, pw_correct, digit_cnt, busy, locked}, 32'd0);
        rst_n = 1'b1;
        step();
        check("idle after reset", {27'd0, pwdone, pw_correct, digit_cnt, busy, locked}, 32'd0);

        // ---- vector table ----
        foreach (vecs[i]) begin
            pwstart = vecs[i].ps;
            digit   = vecs[i].dg;
            strobe  = vecs[i].st;
            clr     = vecs[i].cl;
            pw_set  = vecs[i].set;
            pw_new  = vecs[i].nw;
            step();
            check($sformatf("vec %0d {done,corr,cnt,busy,locked}", i),
                  {26'd0, pwdone, pw_correct, digit_cnt, busy, locked},
                  {26'd0, vecs[i].e_done, vecs[i].e_corr, vecs[i].e_cnt, vecs[i].e_busy, 1'b0});
        end
        strobe = 1'b0; clr = 1'b0; pw_set = 1'b0;

        // ---- entry timeout: one digit then 20 idle cycles ----
        pwstart = 1'b1;
        step();
        digit = 4'h7; strobe = 1'b1;
        step();
        strobe = 1'b0;
        lat = -1;
        c = 1'b1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            step();
            if (pwdone) begin
                lat = i;
                c = pw_correct;
            end
        end
        check("timeout latency", 32'(lat), 32'd20);
        check("timeout pw_correct", {31'd0, c}, 32'd0);
        check("timeout busy", {31'd0, busy}, 32'd0);
        pwstart = 1'b0;
        step();

        // ---- abort after two digits, abort beats a same-cycle strobe ----
        pwstart = 1'b1;
        step();
        digit = 4'h1; strobe = 1'b1;
        step();
        digit = 4'h2;
        step();
        digit = 4'h3; pwstart = 1'b0;
        step();
        strobe = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort ignores strobe", {29'd0, digit_cnt}, 32'd2);
        seen = 1'b0;
        repeat (30) begin
            step();
            if (pwdone) seen = 1'b1;
        end
        check("abort no pwdone", {31'd0, seen}, 32'd0);

        // ---- async reset mid-COLLECT restores 1234 ----
        pwstart = 1'b1;
        step();
        digit = 4'hA; strobe = 1'b1;
        step();
        digit = 4'h5;
        step();
        strobe = 1'b0;
        check("pre-reset state", {27'd0, pwdone, pw_correct, digit_cnt, busy, locked}, 32'b00_010_1_0);
        #2 rst_n = 1'b0;
        #1;
        check("async reset outputs", {27'd0, pwdone, pw_correct, digit_cnt, busy, locked}, 32'd0);
        pwstart = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        run_session(16'h1234, d, c);
        check("post-reset default code {done,corr}", {30'd0, d, c}, 32'b11);
        run_session(16'hA5C3, d, c);
        check("post-reset old code rejected {done,corr}", {30'd0, d, c}, 32'b10);

`ifdef PW_LOCKOUT_EN
        // ---- lockout: two more failures reach three ----
        for (int k = 0; k < 2; k++) begin
            run_session(16'h9999, d, c);
            check($sformatf("lock fail %0d {done,corr}", k), {30'd0, d, c}, 32'b10);
        end
        check("locked asserted", {31'd0, locked}, 32'd1);
        n = 0;
        pwstart = 1'b1; pw_set = 1'b1; pw_new = 16'hFFFF;
        step();
        n++;
        pw_set = 1'b0;
        check("locked request {done,corr,locked}", {29'd0, pwdone, pw_correct, locked}, 32'b101);
        step();
        n++;
        check("locked pwdone single", {31'd0, pwdone}, 32'd0);
        pwstart = 1'b0;
        while (locked && n < 200) begin
            step();
            n++;
        end
        check("lock duration", 32'(n), 32'd50);
        run_session(16'h1234, d, c);
        check("after lockout {done,corr}", {30'd0, d, c}, 32'b11);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
